// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking IDLE/FILL miss engine.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int CACHE_SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W = $clog2(CACHE_SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nxt;
    logic [CACHE_SETS-1:0] valid;
    logic [TAG_W-1:0]  tag_mem  [CACHE_SETS];
    logic [31:0]       data_mem [CACHE_SETS];
    logic [31:0]       miss_addr;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              tag_match;
    logic              miss_start;
    logic              fill_we;

    assign req_idx   = imemaddr[IDX_W+1:2];
    assign req_tag   = imemaddr[31:IDX_W+2];
    assign fill_idx  = miss_addr[IDX_W+1:2];
    assign fill_tag  = miss_addr[31:IDX_W+2];
    assign tag_match = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_nxt  = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (tag_match) begin
                        ihit     = 1'b1;
                        imemload = data_mem[req_idx];
                    end else begin
                        miss_start = 1'b1;
                        state_nxt  = FILL;
                    end
                end
            end
            FILL: begin
                // Fill runs to completion regardless of what the datapath does meanwhile.
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill_we   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            state <= state_nxt;
            if (miss_start)
                miss_addr <= imemaddr & 32'hFFFF_FFFC;
            if (fill_we)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a frame is only observable once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (ihit && (hit_q != 32'hFFFF_FFFF))
                hit_q <= hit_q + 32'd1;
            if (miss_start && (miss_q != 32'hFFFF_FFFF))
                miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scenario bench for icache_dm: a wait-state memory model plus a scoreboard of expected
// instruction words, pushed at request time and popped when ihit is seen.
module tb_icache_dm;
`ifdef ICACHE_STATS_EN
    localparam logic [31:0] STATS = 32'd1;
`else
    localparam logic [31:0] STATS = 32'd0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b0;
    logic [31:0] iload = '0;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;
    int wait_cnt = 0;
    logic [31:0] sb[$];

    icache_dm #(.CACHE_SETS(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_0040) return 32'h8C01_0004;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: wait_cfg busy cycles per request, then data for whatever iaddr holds.
    task automatic mem_drive();
        if (iREN) begin
            if (wait_cnt < wait_cfg) begin
                iwait = 1'b1;
                wait_cnt++;
            end else begin
                iwait = 1'b0;
            end
            iload = mem_word(iaddr);
        end else begin
            wait_cnt = 0;
            iwait = 1'b0;
            iload = '0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        mem_drive();
    endtask

    task automatic do_reset();
        imemREN = 1'b0;
        RST = 1'b1;
        wait_cnt = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_lat, input string nm);
        int lat;
        logic [31:0] exp_w;
        imemREN = 1'b1;
        imemaddr = a;
        sb.push_back(mem_word(a));
        lat = 0;
        @(negedge CLK);
        while (!ihit && lat < 64) begin
            if (iREN) begin
                checks++;
                if (iaddr !== (a & 32'hFFFF_FFFC)) begin
                    errors++;
                    $display("FAIL %s iaddr got %h exp %h", nm, iaddr, a & 32'hFFFF_FFFC);
                end
            end
            tick();
            lat++;
            @(negedge CLK);
        end
        exp_w = sb.pop_front();
        checks++;
        if (ihit !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout waiting for ihit", nm);
        end else if (imemload !== exp_w) begin
            errors++;
            $display("FAIL %s imemload got %h exp %h", nm, imemload, exp_w);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", nm, lat, exp_lat);
        end
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        imemREN = 1'b1;
        imemaddr = 32'h0;
        #3;
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ihit=%b load=%h iREN=%b iaddr=%h exp 0", ihit, imemload, iREN, iaddr);
        end
        checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d exp 0/0", hit_count, miss_count);
        end
        do_reset();
    endtask

    task automatic test_cold_miss();
        wait_cfg = 3;
        imemREN = 1'b1;
        imemaddr = 32'h40;
        sb.push_back(32'h8C01_0004);
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL cold_first_cycle ihit got %b exp 0", ihit);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
                errors++;
                $display("FAIL cold_fill%0d got iREN=%b iaddr=%h ihit=%b exp 1/40/0", i, iREN, iaddr, ihit);
            end
            tick();
        end
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b1 || imemload !== sb.pop_front()) begin
            errors++;
            $display("FAIL cold_hit got ihit=%b load=%h exp 1/8c010004", ihit, imemload);
        end
        checks++;
        if (miss_count !== STATS) begin
            errors++;
            $display("FAIL cold_miss_count got %0d exp %0d", miss_count, STATS);
        end
        tick();
    endtask

    task automatic test_stats();
        int n;
        do_reset();
        wait_cfg = 2;
        imemREN = 1'b1;
        imemaddr = 32'h80;
        n = 0;
        @(negedge CLK);
        while (!ihit && n < 64) begin
            tick();
            n++;
            @(negedge CLK);
        end
        for (int k = 0; k < 5; k++) begin
            sb.push_back(mem_word(32'h80));
            if (k > 0) @(negedge CLK);
            checks++;
            if (ihit !== 1'b1 || imemload !== sb.pop_front()) begin
                errors++;
                $display("FAIL stats_hit%0d got ihit=%b load=%h", k, ihit, imemload);
            end
            tick();
        end
        @(negedge CLK);
        checks++;
        if (hit_count !== 32'd5 * STATS || miss_count !== STATS) begin
            errors++;
            $display("FAIL stats_counts got %0d/%0d exp %0d/%0d", hit_count, miss_count, 32'd5 * STATS, STATS);
        end
        imemREN = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || hit_count !== 32'd5 * STATS) begin
            errors++;
            $display("FAIL stats_idle got ihit=%b load=%h hits=%0d", ihit, imemload, hit_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wait_cfg = 0;
        fetch(32'h0, 2, "b2b_fill0");
        fetch(32'h4, 2, "b2b_fill4");
        fetch(32'h8, 2, "b2b_fill8");
        fetch(32'hC, 2, "b2b_fillC");
        fetch(32'hC, 0, "b2b_hitC");
        fetch(32'h0, 0, "b2b_hit0");
        fetch(32'h8, 0, "b2b_hit8");
        fetch(32'h4, 0, "b2b_hit4");
    endtask

    task automatic test_idle_hold();
        imemREN = 1'b0;
        imemaddr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold%0d got ihit=%b load=%h iREN=%b exp 0", i, ihit, imemload, iREN);
            end
            tick();
        end
        fetch(32'h4, 0, "idle_rehit");
    endtask

    task automatic test_conflict();
        wait_cfg = 1;
        fetch(32'h40, 3, "conflict_fill40");
        fetch(32'h0, 3, "conflict_refill0");
        fetch(32'h0, 0, "conflict_hit0");
    endtask

    task automatic test_addr_change();
        int n;
        wait_cfg = 3;
        imemREN = 1'b1;
        imemaddr = 32'h10;
        tick();
        imemaddr = 32'h20;
        n = 0;
        while (iREN && n < 64) begin
            @(negedge CLK);
            checks++;
            if (iaddr !== 32'h10 || ihit !== 1'b0) begin
                errors++;
                $display("FAIL addr_change_fill got iaddr=%h ihit=%b exp 10/0", iaddr, ihit);
            end
            imemREN = (n != 1);
            tick();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL addr_change_len got %0d exp 4", n);
        end
        fetch(32'h20, 5, "addr_change_miss20");
        fetch(32'h10, 0, "addr_change_hit10");
    endtask

    task automatic test_byte_offset();
        wait_cfg = 1;
        fetch(32'h100, 3, "byte_fill100");
        fetch(32'h103, 0, "byte_hit103");
        fetch(32'h101, 0, "byte_hit101");
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        wait_cfg = 5;
        imemREN = 1'b1;
        imemaddr = 32'h8;
        tick();
        tick();
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h8) begin
            errors++;
            $display("FAIL midrst_fill got iREN=%b iaddr=%h exp 1/8", iREN, iaddr);
        end
        RST = 1'b1;
        imemREN = 1'b0;
        wait_cnt = 0;
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got iREN=%b iaddr=%h ihit=%b exp 0", iREN, iaddr, ihit);
        end
        @(negedge CLK);
        RST = 1'b0;
        tick();
        wait_cfg = 1;
        fetch(32'h8, 3, "midrst_refetch");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_stats();
        test_back_to_back();
        test_idle_hold();
        test_conflict();
        test_addr_change();
        test_byte_offset();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
